bus_response_tracker: RTL and testbench

BUS_RESPONSE_TRACKER -- requirements
Module: bus_response_tracker

---
 rtl/tracker_pkg.sv | 30 +++
 rtl/tracker_timeout_scan.sv | 32 +++
 rtl/bus_response_tracker.sv | 148 ++++++++++++++
 tb/tb_bus_response_tracker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Frame field positions, COB-ID function codes, error codes and per-bus entry layout
// shared by the bus response tracker. TRACKER_MUX_CHECK_EN adds the mux field to the entry.
package tracker_pkg;

    localparam int N_BUS    = 32;
    localparam int FRAME_W  = 76;

    localparam int FC_HI    = 75;
    localparam int FC_LO    = 72;
    localparam int NODE_HI  = 71;
    localparam int NODE_LO  = 65;
    localparam int RSVD_BIT = 64;
    localparam int MUX_HI   = 55;
    localparam int MUX_LO   = 32;

    localparam logic [3:0] FC_TRA = 4'hC;
    localparam logic [3:0] FC_REC = 4'hB;

    localparam logic ERR_UNEXPECTED = 1'b0;
    localparam logic ERR_MISMATCH   = 1'b1;

    typedef struct packed {
        logic [6:0]  node;
`ifdef TRACKER_MUX_CHECK_EN
        logic [23:0] mux;
`endif
        logic [15:0] stamp;
    } entry_t;

endpackage

// File: rtl/tracker_timeout_scan.sv
// Round-robin timeout scanner: visits one bus per cycle and flags a pending entry whose
// age has reached TIMEOUT_CYCLES. A stall holds the pointer and suppresses the flag.
module tracker_timeout_scan
    import tracker_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [N_BUS-1:0] pending,
    input  logic [15:0]      now,
    input  logic [15:0]      ptr_stamp,
    output logic [4:0]       ptr,
    output logic             fire
);

    logic [15:0] age;

    // Modulo-2^16 subtraction keeps the age correct across timestamp wrap.
    assign age  = now - ptr_stamp;
    assign fire = !stall && pending[ptr] && (age >= TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 5'd0;
        end else if (!stall) begin
            ptr <= ptr + 5'd1;
        end
    end

endmodule

// File: rtl/bus_response_tracker.sv
// Tracks one outstanding SDO-style request per bus and classifies uplink responses.
// Define TRACKER_MUX_CHECK_EN to also compare the 24-bit multiplexer field on a response.
module bus_response_tracker
    import tracker_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         n_buses,
    input  logic               tra_valid,
    input  logic [4:0]         can_tra_select,
    input  logic [FRAME_W-1:0] data_tra_downlink,
    input  logic               rec_valid,
    input  logic [4:0]         can_rec_select,
    input  logic [FRAME_W-1:0] data_rec_uplink,
    output logic               match_pulse,
    output logic [4:0]         match_bus,
    output logic               err_pulse,
    output logic               err_code,
    output logic [4:0]         err_bus,
    output logic               ovw_pulse,
    output logic [4:0]         ovw_bus,
    output logic               to_pulse,
    output logic [4:0]         to_bus,
    output logic [N_BUS-1:0]   pending,
    output logic [15:0]        cnt_match,
    output logic [15:0]        cnt_err
);

    entry_t           entry [N_BUS];
    logic [15:0]      timestamp;
    logic [N_BUS-1:0] pending_nxt;
    logic [6:0]       tra_node;
    logic [6:0]       rec_node;
    logic             tra_hit;
    logic             rec_hit;
    logic             rec_same;
    logic             match_evt;
    logic             mism_evt;
    logic             err_evt;
    logic             ovw_evt;
    logic             scan_stall;
    logic             scan_fire;
    logic [4:0]       scan_ptr;
    logic [1:0]       err_inc;
    logic             unused_bits;

    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign tra_node = data_tra_downlink[NODE_HI:NODE_LO];
    assign rec_node = data_rec_uplink[NODE_HI:NODE_LO];

    assign tra_hit = tra_valid && (data_tra_downlink[FC_HI:FC_LO] == FC_TRA)
                     && (can_tra_select <= n_buses);
    assign rec_hit = rec_valid && (data_rec_uplink[FC_HI:FC_LO] == FC_REC)
                     && (can_rec_select <= n_buses) && pending[can_rec_select];

`ifdef TRACKER_MUX_CHECK_EN
    assign rec_same = (entry[can_rec_select].node == rec_node)
                      && (entry[can_rec_select].mux == data_rec_uplink[MUX_HI:MUX_LO]);
    assign unused_bits = ^{data_tra_downlink[RSVD_BIT:MUX_HI+1], data_tra_downlink[MUX_LO-1:0],
                           data_rec_uplink[RSVD_BIT:MUX_HI+1], data_rec_uplink[MUX_LO-1:0]};
`else
    assign rec_same = (entry[can_rec_select].node == rec_node);
    assign unused_bits = ^{data_tra_downlink[RSVD_BIT:0], data_rec_uplink[RSVD_BIT:0]};
`endif

    assign match_evt = rec_hit && rec_same;
    assign mism_evt  = rec_hit && !rec_same;
    assign err_evt   = rec_valid && !match_evt;
    // A response consuming the entry in the same cycle leaves nothing to overwrite.
    assign ovw_evt   = tra_hit && pending[can_tra_select]
                       && !(rec_hit && (can_rec_select == can_tra_select));
    assign err_inc   = {1'b0, err_evt} + {1'b0, ovw_evt} + {1'b0, scan_fire};

    assign scan_stall = (tra_hit && (can_tra_select == scan_ptr))
                        || (rec_valid && (can_rec_select == scan_ptr));

    tracker_timeout_scan #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .stall    (scan_stall),
        .pending  (pending),
        .now      (timestamp),
        .ptr_stamp(entry[scan_ptr].stamp),
        .ptr      (scan_ptr),
        .fire     (scan_fire)
    );

    // Clears before set so a same-cycle response and request leave the new entry pending.
    always_comb begin
        pending_nxt = pending;
        if (rec_hit)   pending_nxt[can_rec_select] = 1'b0;
        if (scan_fire) pending_nxt[scan_ptr]       = 1'b0;
        if (tra_hit)   pending_nxt[can_tra_select] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timestamp   <= 16'd0;
            pending     <= '0;
            match_pulse <= 1'b0;
            match_bus   <= 5'd0;
            err_pulse   <= 1'b0;
            err_code    <= ERR_UNEXPECTED;
            err_bus     <= 5'd0;
            ovw_pulse   <= 1'b0;
            ovw_bus     <= 5'd0;
            to_pulse    <= 1'b0;
            to_bus      <= 5'd0;
            cnt_match   <= 16'd0;
            cnt_err     <= 16'd0;
        end else begin
            timestamp   <= timestamp + 16'd1;
            pending     <= pending_nxt;
            match_pulse <= match_evt;
            match_bus   <= match_evt ? can_rec_select : 5'd0;
            err_pulse   <= err_evt;
            err_code    <= mism_evt ? ERR_MISMATCH : ERR_UNEXPECTED;
            err_bus     <= err_evt ? can_rec_select : 5'd0;
            ovw_pulse   <= ovw_evt;
            ovw_bus     <= ovw_evt ? can_tra_select : 5'd0;
            to_pulse    <= scan_fire;
            to_bus      <= scan_fire ? scan_ptr : 5'd0;
            cnt_match   <= sat_add(cnt_match, {1'b0, match_evt});
            cnt_err     <= sat_add(cnt_err, err_inc);
        end
    end

    // Entry payload is only meaningful while its pending bit is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (tra_hit) begin
            entry[can_tra_select].node  <= tra_node;
`ifdef TRACKER_MUX_CHECK_EN
            entry[can_tra_select].mux   <= data_tra_downlink[MUX_HI:MUX_LO];
`endif
            entry[can_tra_select].stamp <= timestamp;
        end
    end

endmodule

// File: tb/tb_bus_response_tracker.sv
// Randomized and directed bench for bus_response_tracker against a cycle-level reference
// model of the request/response/timeout rules (TIMEOUT_CYCLES = 100).
module tb_bus_response_tracker;

    localparam int TOUT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  n_buses = 5'd31;
    logic        tra_valid = 1'b0;
    logic [4:0]  can_tra_select = 5'd0;
    logic [75:0] data_tra_downlink = '0;
    logic        rec_valid = 1'b0;
    logic [4:0]  can_rec_select = 5'd0;
    logic [75:0] data_rec_uplink = '0;
    logic        match_pulse, err_pulse, err_code, ovw_pulse, to_pulse;
    logic [4:0]  match_bus, err_bus, ovw_bus, to_bus;
    logic [31:0] pending;
    logic [15:0] cnt_match, cnt_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pend;
    logic [6:0]  m_node [32];
    logic [23:0] m_mux  [32];
    int          m_stamp[32];
    int          m_ts, m_ptr, m_cm, m_ce;
    bit          e_match, e_err, e_code, e_ovw, e_to;
    int          e_mbus, e_ebus, e_obus, e_tbus;

    always #5 clk = ~clk;

    bus_response_tracker #(.TIMEOUT_CYCLES(16'(TOUT))) dut (
        .clk(clk), .rst(rst), .n_buses(n_buses),
        .tra_valid(tra_valid), .can_tra_select(can_tra_select), .data_tra_downlink(data_tra_downlink),
        .rec_valid(rec_valid), .can_rec_select(can_rec_select), .data_rec_uplink(data_rec_uplink),
        .match_pulse(match_pulse), .match_bus(match_bus),
        .err_pulse(err_pulse), .err_code(err_code), .err_bus(err_bus),
        .ovw_pulse(ovw_pulse), .ovw_bus(ovw_bus),
        .to_pulse(to_pulse), .to_bus(to_bus),
        .pending(pending), .cnt_match(cnt_match), .cnt_err(cnt_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [75:0] mk_frame(input logic [10:0] cob, input logic [23:0] mux);
        return {cob, 1'b0, 8'($urandom), mux, 32'($urandom)};
    endfunction

    // Apply the tracker rules to the current inputs; model state becomes the post-edge state.
    task automatic model_eval();
        bit t_hit, r_acc, same, stall;
        int tb, rb;
        e_match = 0; e_err = 0; e_code = 0; e_ovw = 0; e_to = 0;
        if (rst) begin
            m_pend = '0; m_ts = 0; m_ptr = 0; m_cm = 0; m_ce = 0;
            return;
        end
        tb = int'(can_tra_select);
        rb = int'(can_rec_select);
        t_hit = tra_valid && data_tra_downlink[75:72] == 4'hC && tb <= int'(n_buses);
        r_acc = rec_valid && data_rec_uplink[75:72] == 4'hB && rb <= int'(n_buses) && m_pend[rb];
        e_mbus = rb; e_ebus = rb; e_obus = tb; e_tbus = m_ptr;
        if (rec_valid) begin
            if (r_acc) begin
                same = (m_node[rb] == data_rec_uplink[71:65]);
`ifdef TRACKER_MUX_CHECK_EN
                same = same && (m_mux[rb] == data_rec_uplink[55:32]);
`endif
                if (same) e_match = 1;
                else begin e_err = 1; e_code = 1; end
            end else begin
                e_err = 1;
            end
        end
        e_ovw = t_hit && m_pend[tb] && !(r_acc && rb == tb);
        stall = (t_hit && tb == m_ptr) || (rec_valid && rb == m_ptr);
        e_to  = !stall && m_pend[m_ptr] && (((m_ts - m_stamp[m_ptr]) & 65535) >= TOUT);
        if (r_acc) m_pend[rb] = 1'b0;
        if (e_to)  m_pend[m_ptr] = 1'b0;
        if (t_hit) begin
            m_pend[tb]  = 1'b1;
            m_node[tb]  = data_tra_downlink[71:65];
            m_mux[tb]   = data_tra_downlink[55:32];
            m_stamp[tb] = m_ts;
        end
        if (!stall) m_ptr = (m_ptr + 1) % 32;
        m_ts = (m_ts + 1) % 65536;
        m_cm = (m_cm + int'(e_match) > 65535) ? 65535 : m_cm + int'(e_match);
        m_ce = (m_ce + int'(e_err) + int'(e_ovw) + int'(e_to) > 65535) ? 65535
             : m_ce + int'(e_err) + int'(e_ovw) + int'(e_to);
    endtask

    task automatic compare();
        check("match_pulse", 32'(match_pulse), 32'(e_match));
        check("err_pulse",   32'(err_pulse),   32'(e_err));
        check("ovw_pulse",   32'(ovw_pulse),   32'(e_ovw));
        check("to_pulse",    32'(to_pulse),    32'(e_to));
        check("pending",     pending,          m_pend);
        check("cnt_match",   32'(cnt_match),   32'(m_cm));
        check("cnt_err",     32'(cnt_err),     32'(m_ce));
        if (e_match) check("match_bus", 32'(match_bus), 32'(e_mbus));
        if (e_err) begin
            check("err_code", 32'(err_code), 32'(e_code));
            check("err_bus",  32'(err_bus),  32'(e_ebus));
        end
        if (e_ovw) check("ovw_bus", 32'(ovw_bus), 32'(e_obus));
        if (e_to)  check("to_bus",  32'(to_bus),  32'(e_tbus));
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic clr();
        tra_valid = 1'b0;
        rec_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) step();
    endtask

    task automatic set_tra(input int bus, input logic [10:0] cob, input logic [23:0] mux);
        tra_valid = 1'b1;
        can_tra_select = 5'(bus);
        data_tra_downlink = mk_frame(cob, mux);
    endtask

    task automatic set_rec(input int bus, input logic [10:0] cob, input logic [23:0] mux);
        rec_valid = 1'b1;
        can_rec_select = 5'(bus);
        data_rec_uplink = mk_frame(cob, mux);
    endtask

    initial begin
        int seen;
        int to_seen;
        logic [4:0]  rb;
        logic [6:0]  node;
        logic [23:0] mux;
        logic [3:0]  fc;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_pending", pending, 32'd0);
        check("rst_cnt_match", 32'(cnt_match), 32'd0);
        check("rst_cnt_err", 32'(cnt_err), 32'd0);
        check("rst_pulses", 32'({match_pulse, err_pulse, ovw_pulse, to_pulse}), 32'd0);

        // Matching response ten cycles after the request
        set_tra(3, 11'h605, 24'h201801);
        step();
        idle(9);
        set_rec(3, 11'h585, 24'h201801);
        step();
        clr();
        check("req034_match", 32'(match_pulse), 32'd1);
        check("req034_bus", 32'(match_bus), 32'd3);
        check("req034_pend3", 32'(pending[3]), 32'd0);
        check("req034_cnt", 32'(cnt_match), 32'd1);

        // Unexpected response
        set_rec(7, 11'h587, 24'h0);
        step();
        clr();
        check("req035_err", 32'({err_pulse, err_code}), 32'b10);
        check("req035_bus", 32'(err_bus), 32'd7);
        check("req035_cnt", 32'(cnt_err), 32'd1);

        // Out-of-range bus: request ignored, response unexpected
        n_buses = 5'd3;
        set_tra(5, 11'h605, 24'h1);
        step();
        clr();
        check("range_tra_ignored", 32'(pending[5]), 32'd0);
        set_rec(5, 11'h585, 24'h1);
        step();
        clr();
        check("range_rec_err", 32'({err_pulse, err_code}), 32'b10);
        n_buses = 5'd31;

        // Timeout on bus 31
        set_tra(31, 11'h61F, 24'h000001);
        step();
        clr();
        seen = -1;
        for (int k = 1; k <= 140 && seen < 0; k++) begin
            step();
            if (to_pulse && to_bus == 5'd31) seen = k;
        end
        check("req036_to_seen", 32'(seen >= 101 && seen <= 134), 32'd1);
        check("req036_pend31", 32'(pending[31]), 32'd0);

        // Same-cycle response and new request on bus 5, then an overwrite
        set_tra(5, 11'h605, 24'h0000A1);
        step();
        idle(3);
        set_rec(5, 11'h585, 24'h0000A1);
        set_tra(5, 11'h606, 24'h0000B2);
        step();
        clr();
        check("req037_match", 32'(match_pulse), 32'd1);
        check("req037_no_ovw", 32'(ovw_pulse), 32'd0);
        check("req037_pend5", 32'(pending[5]), 32'd1);
        set_tra(5, 11'h607, 24'h0000C3);
        step();
        clr();
        check("req037_ovw", 32'(ovw_pulse), 32'd1);
        check("req037_ovw_bus", 32'(ovw_bus), 32'd5);
        set_rec(5, 11'h587, 24'h0000C3);
        step();
        clr();
        check("req037_new_entry", 32'(match_pulse), 32'd1);

        // Mux mismatch
        set_tra(9, 11'h609, 24'h201801);
        step();
        idle(1);
        set_rec(9, 11'h589, 24'h201802);
        step();
        clr();
`ifdef TRACKER_MUX_CHECK_EN
        check("req038_mux_err", 32'({err_pulse, err_code}), 32'b11);
`else
        check("req038_mux_match", 32'(match_pulse), 32'd1);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 0) n_buses = (c == 1200) ? 5'd3 : (c == 2400) ? 5'd15 : 5'd31;
            tra_valid = ($urandom_range(3) == 0);
            can_tra_select = 5'($urandom);
            fc = ($urandom_range(9) == 0) ? 4'h5 : 4'hC;
            data_tra_downlink = mk_frame({fc, 7'($urandom_range(3))},
                                         {16'h2018, 8'($urandom_range(3))});
            rb = 5'($urandom);
            if (!m_pend[rb]) rb = 5'($urandom);
            node = 7'($urandom_range(3));
            mux = {16'h2018, 8'($urandom_range(3))};
            if (m_pend[rb] && $urandom_range(9) < 7) begin
                node = m_node[rb];
                mux = m_mux[rb];
                if ($urandom_range(4) == 0) mux[0] = ~mux[0];
            end
            fc = ($urandom_range(9) == 0) ? 4'h7 : 4'hB;
            rec_valid = ($urandom_range(3) == 0);
            can_rec_select = rb;
            data_rec_uplink = mk_frame({fc, node}, mux);
            step();
        end
        clr();
        n_buses = 5'd31;

        // Reset with requests outstanding; inputs in the reset cycle are ignored
        set_tra(1, 11'h601, 24'h1); step();
        set_tra(2, 11'h602, 24'h2); step();
        set_tra(8, 11'h608, 24'h3); step();
        set_tra(20, 11'h614, 24'h4); step();
        clr();
        rst = 1'b1;
        set_tra(6, 11'h606, 24'h5);
        set_rec(1, 11'h581, 24'h1);
        step();
        rst = 1'b0;
        clr();
        check("rst2_pending", pending, 32'd0);
        check("rst2_cnts", {cnt_match, cnt_err}, 32'd0);
        to_seen = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (to_pulse) to_seen++;
        end
        check("rst2_no_timeout", 32'(to_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
